// File: rtl/queens_reader.sv
// queens_reader: scans solver rows column by column, streams them out and flags row/diagonal conflicts.
module queens_reader #(
  parameter int W  = 5,
  parameter int DW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] n,
  output logic [W-1:0] row_query,
  input  logic [W-1:0] row_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_col,
  output logic [W-1:0] out_row,
  output logic         out_conflict,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         ok,
  output logic [W-1:0] bad_col
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  state_t state, state_next;
  logic [W-1:0] n_r, col, bad_r;
  logic ok_r;
  logic [2**W-1:0] rused;
  logic [2**DW-1:0] d1, d2;
  logic [DW-1:0] d1i, d2i;
  logic in_range, conflict, last, accept;
  assign in_range = row_result < n_r;
  // n + col - r cannot underflow once r < n, so DW bits suffice
  assign d1i = DW'(row_result) + DW'(col);
  assign d2i = DW'(n_r) + DW'(col) - DW'(row_result);
  assign conflict = !in_range || rused[row_result] || d1[d1i] || d2[d2i];
  assign last = col == n_r - W'(1);
  assign accept = (state == IDLE || state == DONE) && start;
  assign row_query = col;
  assign out_col = col;
  assign out_valid = state == SEND;
  assign out_last = out_valid && last;
  assign busy = state == FETCH || state == SEND;
  assign done = state == DONE;
  assign ok = done && ok_r;
  assign bad_col = done ? bad_r : '0;
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (n == '0) ? DONE : FETCH;
      FETCH:      state_next = SEND;
      SEND:       if (out_ready) state_next = last ? DONE : FETCH;
      default:    state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk)
    if (!reset) begin
      n_r <= '0;
      col <= '0;
      out_row <= '0;
      out_conflict <= 1'b0;
      ok_r <= 1'b1;
      bad_r <= '0;
    end else if (accept) begin
      n_r <= n;
      col <= '0;
      ok_r <= 1'b1;
      bad_r <= '0;
    end else if (state == FETCH) begin
      out_row <= row_result;
      out_conflict <= conflict;
      if (conflict && ok_r) begin
        ok_r <= 1'b0;
        bad_r <= col;
      end
    end else if (state == SEND && out_ready && !last)
      col <= col + W'(1);
  // occupancy maps only need clearing when a scan starts
  always_ff @(posedge clk)
    if (accept) begin
      rused <= '0;
      d1 <= '0;
      d2 <= '0;
    end else if (state == FETCH && in_range) begin
      rused[row_result] <= 1'b1;
      d1[d1i] <= 1'b1;
      d2[d2i] <= 1'b1;
    end
endmodule

// File: tb/tb_queens_reader.sv
// tb_queens_reader: directed scenarios for queens_reader with a combinational solver model.
module tb_queens_reader;
  logic clk = 0, reset, start, out_ready;
  logic [4:0] n, row_query, row_result, out_col, out_row, bad_col;
  logic out_valid, out_conflict, out_last, busy, done, ok;
  logic [4:0] rows[32];
  int pass_cnt = 0, total_cnt = 0;
  logic [4:0] bc[8], br[8];
  logic bf[8], bl[8];
  int nb, cyc_done, fv, stab_err;
  logic busy1;
  logic [4:0] rq1;
  assign row_result = rows[row_query];
  always #5 clk = ~clk;
  queens_reader #(.W(5), .DW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .row_query(row_query),
    .row_result(row_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_row(out_row), .out_conflict(out_conflict),
    .out_last(out_last), .busy(busy), .done(done), .ok(ok), .bad_col(bad_col)
  );
  task automatic load(input logic [4:0] a, b, c, d, e, f, g, h);
    for (int i = 0; i < 32; i++) rows[i] = 5'd0;
    rows[0] = a; rows[1] = b; rows[2] = c; rows[3] = d;
    rows[4] = e; rows[5] = f; rows[6] = g; rows[7] = h;
  endtask
  task automatic pulse_start(input logic [4:0] nn);
    n = nn;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic collect(input int mode);
    logic prev_stall;
    logic [11:0] prev;
    nb = 0; cyc_done = -1; fv = -1; stab_err = 0; prev_stall = 0; prev = '0;
    for (int c = 1; c <= 300; c++) begin
      if (c == 1) begin busy1 = busy; rq1 = row_query; end
      if (done) begin cyc_done = c; break; end
      if (out_valid && fv < 0) fv = c;
      if (prev_stall && {out_col, out_row, out_conflict, out_last} !== prev) stab_err++;
      out_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      prev_stall = out_valid && !out_ready;
      prev = {out_col, out_row, out_conflict, out_last};
      if (out_valid && out_ready && nb < 8) begin
        bc[nb] = out_col; br[nb] = out_row; bf[nb] = out_conflict; bl[nb] = out_last;
        nb++;
      end
      @(negedge clk);
    end
    out_ready = 1;
  endtask
  task automatic test_reset;
    reset = 0; start = 0; n = 0; out_ready = 1;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({row_query, out_valid, out_col, out_row, out_conflict, out_last, busy, done, ok, bad_col} !== 27'd0)
      $display("FAIL reset_outputs got %b want all zero",
               {row_query, out_valid, out_col, out_row, out_conflict, out_last, busy, done, ok, bad_col});
    else pass_cnt++;
    reset = 1;
    @(negedge clk);
  endtask
  task automatic test_clean;
    load(1, 3, 0, 2, 0, 0, 0, 0);
    pulse_start(4);
    collect(0);
    total_cnt++; if (busy1 !== 1'b1 || rq1 !== 5'd0) $display("FAIL clean_fetch busy=%b rq=%0d want 1/0", busy1, rq1); else pass_cnt++;
    total_cnt++; if (fv !== 2) $display("FAIL clean_first_valid got %0d want 2", fv); else pass_cnt++;
    total_cnt++; if (nb !== 4) $display("FAIL clean_beats got %0d want 4", nb); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] ci = 5'(i);
      total_cnt++;
      if ({bc[i], br[i], bf[i], bl[i]} !== {ci, rows[i], 1'b0, i == 3})
        $display("FAIL clean_beat%0d got col=%0d row=%0d c=%b l=%b want col=%0d row=%0d c=0 l=%b", i, bc[i], br[i], bf[i], bl[i], ci, rows[i], i == 3);
      else pass_cnt++;
    end
    total_cnt++; if (cyc_done !== 9) $display("FAIL clean_done_cycle got %0d want 9", cyc_done); else pass_cnt++;
    total_cnt++; if (ok !== 1'b1 || bad_col !== 5'd0) $display("FAIL clean_verdict ok=%b bad=%0d want 1/0", ok, bad_col); else pass_cnt++;
  endtask
  task automatic test_diag;
    logic [3:0] ec = 4'b1010;
    load(0, 1, 3, 2, 0, 0, 0, 0);
    pulse_start(4);
    collect(0);
    total_cnt++; if (nb !== 4) $display("FAIL diag_beats got %0d want 4", nb); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({br[i], bf[i]} !== {rows[i], ec[i]}) $display("FAIL diag_beat%0d row=%0d c=%b want row=%0d c=%b", i, br[i], bf[i], rows[i], ec[i]);
      else pass_cnt++;
    end
    total_cnt++; if (ok !== 1'b0 || bad_col !== 5'd1) $display("FAIL diag_verdict ok=%b bad=%0d want 0/1", ok, bad_col); else pass_cnt++;
  endtask
  task automatic test_range;
    logic [3:0] ec = 4'b0100;
    load(1, 3, 5, 2, 0, 0, 0, 0);
    pulse_start(4);
    collect(0);
    total_cnt++; if (nb !== 4) $display("FAIL range_beats got %0d want 4", nb); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({br[i], bf[i]} !== {rows[i], ec[i]}) $display("FAIL range_beat%0d row=%0d c=%b want row=%0d c=%b", i, br[i], bf[i], rows[i], ec[i]);
      else pass_cnt++;
    end
    total_cnt++; if (ok !== 1'b0 || bad_col !== 5'd2) $display("FAIL range_verdict ok=%b bad=%0d want 0/2", ok, bad_col); else pass_cnt++;
  endtask
  task automatic test_stall;
    load(0, 4, 7, 5, 2, 6, 1, 3);
    pulse_start(8);
    collect(1);
    total_cnt++; if (nb !== 8) $display("FAIL stall_beats got %0d want 8", nb); else pass_cnt++;
    total_cnt++; if (stab_err !== 0) $display("FAIL stall_stability got %0d changes want 0", stab_err); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      logic [4:0] ci = 5'(i);
      total_cnt++;
      if ({bc[i], br[i], bf[i], bl[i]} !== {ci, rows[i], 1'b0, i == 7})
        $display("FAIL stall_beat%0d got col=%0d row=%0d c=%b l=%b want col=%0d row=%0d", i, bc[i], br[i], bf[i], bl[i], ci, rows[i]);
      else pass_cnt++;
    end
    total_cnt++; if (ok !== 1'b1 || cyc_done < 0) $display("FAIL stall_verdict ok=%b done_cycle=%0d want 1/reached", ok, cyc_done); else pass_cnt++;
  endtask
  task automatic test_mid_reset;
    load(0, 4, 7, 5, 2, 6, 1, 3);
    out_ready = 1;
    pulse_start(8);
    repeat (5) @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1 || out_col !== 5'd2) $display("FAIL midrst_send2 valid=%b col=%0d want 1/2", out_valid, out_col); else pass_cnt++;
    reset = 0;
    @(negedge clk);
    total_cnt++;
    if ({row_query, out_valid, out_col, out_row, out_conflict, out_last, busy, done, ok, bad_col} !== 27'd0)
      $display("FAIL midrst_outputs got %b want all zero",
               {row_query, out_valid, out_col, out_row, out_conflict, out_last, busy, done, ok, bad_col});
    else pass_cnt++;
    reset = 1;
    @(negedge clk);
    pulse_start(8);
    collect(0);
    total_cnt++; if (nb !== 8 || bc[0] !== 5'd0) $display("FAIL midrst_rescan beats=%0d first_col=%0d want 8/0", nb, bc[0]); else pass_cnt++;
    total_cnt++; if (cyc_done !== 17 || ok !== 1'b1) $display("FAIL midrst_verdict done_cycle=%0d ok=%b want 17/1", cyc_done, ok); else pass_cnt++;
  endtask
  task automatic test_small;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    pulse_start(1);
    collect(0);
    total_cnt++; if (nb !== 1 || {bc[0], br[0], bf[0], bl[0]} !== 12'b00000_00000_01) $display("FAIL n1_beat nb=%0d col=%0d row=%0d c=%b l=%b want 1 beat 0,0,0,1", nb, bc[0], br[0], bf[0], bl[0]); else pass_cnt++;
    total_cnt++; if (cyc_done !== 3 || ok !== 1'b1) $display("FAIL n1_verdict done_cycle=%0d ok=%b want 3/1", cyc_done, ok); else pass_cnt++;
    pulse_start(0);
    collect(0);
    total_cnt++; if (nb !== 0 || cyc_done !== 1 || ok !== 1'b1) $display("FAIL n0 beats=%0d done_cycle=%0d ok=%b want 0/1/1", nb, cyc_done, ok); else pass_cnt++;
  endtask
  task automatic test_busy_start;
    load(0, 1, 3, 2, 0, 0, 0, 0);
    pulse_start(4);
    start = 1; n = 1;
    @(negedge clk);
    start = 0;
    collect(0);
    total_cnt++; if (nb !== 4 || cyc_done !== 8) $display("FAIL busy_start beats=%0d done_cycle=%0d want 4/8", nb, cyc_done); else pass_cnt++;
    total_cnt++; if (ok !== 1'b0 || bad_col !== 5'd1) $display("FAIL busy_start_verdict ok=%b bad=%0d want 0/1", ok, bad_col); else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    load(1, 3, 0, 2, 0, 0, 0, 0);
    pulse_start(4);
    collect(0);
    pulse_start(4);
    collect(0);
    total_cnt++; if (nb !== 4 || cyc_done !== 9 || ok !== 1'b1) $display("FAIL b2b beats=%0d done_cycle=%0d ok=%b want 4/9/1", nb, cyc_done, ok); else pass_cnt++;
  endtask
  initial begin
    test_reset;
    test_clean;
    test_diag;
    test_range;
    test_stall;
    test_mid_reset;
    test_small;
    test_busy_start;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
